mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage. Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and owns the architectural HI/LO registers.
- Services MTHI/MTLO/MFHI/MFLO.
- Drives `busy`, which the hazard/stall unit consumes as HILO_busy to hold any HI/LO-class instruction in D.

Parameters:
- MULT_CYCLES, 5, cycles from start edge to HI/LO update for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles from start edge to HI/LO update for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- mdu_op  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- flush  input  1  E-stage instruction cancelled (exception/interrupt); suppresses any state change this cycle
- busy  output  1  HI/LO unavailable
- HI  output  32  HI register
- LO  output  32  LO register
- mdu_out  output  32  MFHI→HI, MFLO→LO, else 0 (combinational)

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-high.
- Reset values: HI=0, LO=0, counter=0, temp_hi/temp_lo=0, busy=0. Reset wins over all other inputs, including mid-operation; the in-flight result is discarded.
- start = (mdu_op ∈ {1,2,3,4}) & ~flush & (counter==0).
- busy = start | (counter != 0). It is combinational so the stall unit sees it in the start cycle itself.
- On the start edge, operands are computed and latched:
  - MULT: {temp_hi,temp_lo} = signed 64-bit A*B.
  - MULTU: unsigned 64-bit A*B.
  - DIV: temp_lo = signed quotient truncated toward zero; temp_hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - B==0 (DIV/DIVU): latch a div0 flag. The operation still runs DIV_CYCLES, then HI/LO retain their old values.
- Counter: loaded with MULT_CYCLES or DIV_CYCLES on the start edge. It decrements each edge while nonzero. On the edge where counter==1, HI<=temp_hi and LO<=temp_lo (unless div0), and counter becomes 0.
- Timing: start sampled in cycle 0. busy is high in cycles 0..N (N+1 cycles). New HI/LO are visible and busy=0 from cycle N+1.
- mdu_op ∈ {1..4} while counter!=0: ignored. The stall unit guarantees this does not happen; the block must not corrupt state if it does.
- MTHI/MTLO:
  - When ~flush & counter==0, HI<=A (7) or LO<=A (8) at the edge; visible the next cycle.
  - Ignored while counter!=0 or when flush=1.
- MFHI/MFLO: mdu_out reflects the current registered HI/LO with no bypass from temp. The stall unit holds MF* until busy=0.
- flush: blocks start and MT* in the same cycle only. It does not cancel an operation already in flight (counter!=0); that operation completes and writes HI/LO.
- Counter width: wide enough for max(MULT_CYCLES, DIV_CYCLES). No wrap: a decrement at 0 is never performed.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 → busy=1 for cycles 0..5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU A=7, B=2 → busy for 11 cycles; then LO=3, HI=1. DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x1234, next cycle MFLO/MFHI → mdu_out=0x1234 on MFHI. DIVU A=9, B=0 → busy 11 cycles; HI stays 0x1234 and LO stays at its old value.
- MULT with flush=1 in the same cycle → busy=0 throughout, HI/LO unchanged. MULT then flush=1 on cycle 2 → completes normally at cycle 6.
- DIV started, MTLO A=0xDEAD issued at cycle 3 → ignored; final LO = quotient. Second MULT at cycle 4 → ignored, busy pattern unchanged.
- reset asserted at cycle 4 of a DIV → next cycle busy=0, HI=LO=0, counter=0. A new MULT issued right after completes in MULT_CYCLES.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/MULTU/DIV/DIVU,
// owns the architectural HI/LO pair and services MTHI/MTLO/MFHI/MFLO.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] counter;
  logic [31:0]      temp_hi;
  logic [31:0]      temp_lo;
  logic             div0;

  logic             idle;
  logic             is_arith;
  logic             start;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             div_zero;
  logic             div_ovf;
  logic [31:0]      sdivisor;
  logic [31:0]      udivisor;
  logic [31:0]      quot_s;
  logic [31:0]      rem_s;
  logic [31:0]      quot_u;
  logic [31:0]      rem_u;

  logic [31:0]      next_hi;
  logic [31:0]      next_lo;
  logic             next_div0;
  logic [CNT_W-1:0] load_cycles;

  assign idle     = (counter == '0);
  assign is_arith = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                    (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign start    = is_arith && !flush && idle;
  assign busy     = start || !idle;

  // Divisor is forced to 1 for B==0 (result discarded anyway) and for
  // 0x80000000 / -1, where A/1 already yields the wrapped quotient and zero remainder.
  always_comb begin
    prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u   = {32'b0, A} * {32'b0, B};
    div_zero = (B == '0);
    div_ovf  = (A == 32'h8000_0000) && (B == '1);
    sdivisor = (div_zero || div_ovf) ? 32'd1 : B;
    udivisor = div_zero ? 32'd1 : B;
    quot_s   = $signed(A) / $signed(sdivisor);
    rem_s    = $signed(A) % $signed(sdivisor);
    quot_u   = A / udivisor;
    rem_u    = A % udivisor;
  end

  always_comb begin
    next_hi     = '0;
    next_lo     = '0;
    next_div0   = 1'b0;
    load_cycles = CNT_W'(MULT_CYCLES);
    case (mdu_op)
      OP_MULT: begin
        next_hi = prod_s[63:32];
        next_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        next_hi = prod_u[63:32];
        next_lo = prod_u[31:0];
      end
      OP_DIV: begin
        next_hi     = rem_s;
        next_lo     = quot_s;
        next_div0   = div_zero;
        load_cycles = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        next_hi     = rem_u;
        next_lo     = quot_u;
        next_div0   = div_zero;
        load_cycles = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      div0    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (start) begin
      counter <= load_cycles;
      temp_hi <= next_hi;
      temp_lo <= next_lo;
      div0    <= next_div0;
    end else if (!idle) begin
      // In-flight operations ignore flush and any new HI/LO-class op.
      counter <= counter - CNT_W'(1);
      if (counter == CNT_W'(1) && !div0) begin
        HI <= temp_hi;
        LO <= temp_lo;
      end
    end else if (!flush) begin
      if (mdu_op == OP_MTHI) HI <= A;
      if (mdu_op == OP_MTLO) LO <= A;
    end
  end

  always_comb begin
    mdu_out = '0;
    if (mdu_op == OP_MFHI) mdu_out = HI;
    if (mdu_op == OP_MFLO) mdu_out = LO;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed HI/LO/latency expectations.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mdu_out;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op), .A(A), .B(B), .flush(flush),
    .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: remaining-cycle count plus a pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  logic        p_div0 = 1'b0;
  int          left = 0;

  always @(posedge clk) begin : model
    longint sa, sb, q, r;
    logic [63:0] prod;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    if (reset) begin
      m_hi <= '0; m_lo <= '0; left <= 0; p_div0 <= 1'b0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1 && !p_div0) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (!flush) begin
      case (mdu_op)
        4'd1: begin
          prod = sa * sb;
          p_hi <= prod[63:32]; p_lo <= prod[31:0]; p_div0 <= 1'b0; left <= MC;
        end
        4'd2: begin
          prod = {32'b0, A} * {32'b0, B};
          p_hi <= prod[63:32]; p_lo <= prod[31:0]; p_div0 <= 1'b0; left <= MC;
        end
        4'd3: begin
          left <= DC;
          p_div0 <= (B == 0);
          if (B != 0) begin
            q = sa / sb; r = sa % sb;
            p_lo <= q[31:0]; p_hi <= r[31:0];
          end
        end
        4'd4: begin
          left <= DC;
          p_div0 <= (B == 0);
          if (B != 0) begin
            p_lo <= A / B; p_hi <= A % B;
          end
        end
        4'd7: m_hi <= A;
        4'd8: m_lo <= A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    logic exp_busy;
    logic [31:0] exp_out;
    exp_busy = (left != 0) || ((mdu_op >= 4'd1) && (mdu_op <= 4'd4) && !flush);
    exp_out  = (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0;
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("mdu_out", mdu_out, exp_out);
  end

  // Issues op in cycle 0; optional injections at cycles c1/c2 while busy.
  // Returns the number of cycles busy was seen high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl,
                        input int c1, input logic [3:0] op1, input logic [31:0] a1, input logic f1,
                        input int c2, input logic [3:0] op2, input logic [31:0] a2,
                        output int nb);
    @(posedge clk); #1;
    mdu_op = op; A = a; B = b; flush = fl; nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      @(posedge clk); #1;
      mdu_op = (i == c1) ? op1 : (i == c2) ? op2 : 4'd0;
      A      = (i == c1) ? a1  : (i == c2) ? a2  : a;
      flush  = (i == c1) ? f1  : 1'b0;
    end
  endtask

  task automatic simple_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int nb);
    run_op(op, a, b, 1'b0, 0, 4'd0, '0, 1'b0, 0, 4'd0, '0, nb);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nb;
    tick; tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);

    simple_op(4'd1, 32'hFFFF_FFFD, 32'd5, nb);
    chk("mult_len", nb, MC + 1);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFF1);

    simple_op(4'd2, 32'hFFFF_FFFD, 32'd5, nb);
    chk("multu_len", nb, MC + 1);
    chk("multu_HI", HI, 32'h0000_0004);
    chk("multu_LO", LO, 32'hFFFF_FFF1);

    simple_op(4'd4, 32'd7, 32'd2, nb);
    chk("divu_len", nb, DC + 1);
    chk("divu_LO", LO, 32'd3);
    chk("divu_HI", HI, 32'd1);

    simple_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_neg_LO", LO, 32'hFFFF_FFFD);
    chk("div_neg_HI", HI, 32'hFFFF_FFFF);

    simple_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("div_ovf_LO", LO, 32'h8000_0000);
    chk("div_ovf_HI", HI, 32'd0);

    tick; mdu_op = 4'd7; A = 32'h1234;
    tick; mdu_op = 4'd6;
    @(negedge clk);
    chk("mflo_out", mdu_out, 32'h8000_0000);
    tick; mdu_op = 4'd5;
    @(negedge clk);
    chk("mfhi_out", mdu_out, 32'h1234);

    simple_op(4'd4, 32'd9, 32'd0, nb);
    chk("div0_len", nb, DC + 1);
    chk("div0_HI", HI, 32'h1234);
    chk("div0_LO", LO, 32'h8000_0000);

    run_op(4'd1, 32'd3, 32'd3, 1'b1, 0, 4'd0, '0, 1'b0, 0, 4'd0, '0, nb);
    chk("flush_len", nb, 0);
    chk("flush_HI", HI, 32'h1234);
    chk("flush_LO", LO, 32'h8000_0000);

    run_op(4'd1, 32'd3, 32'd4, 1'b0, 2, 4'd0, '0, 1'b1, 0, 4'd0, '0, nb);
    chk("lateflush_len", nb, MC + 1);
    chk("lateflush_LO", LO, 32'd12);
    chk("lateflush_HI", HI, 32'd0);

    run_op(4'd3, 32'd100, 32'd7, 1'b0, 3, 4'd8, 32'hDEAD, 1'b0, 4, 4'd1, 32'd2, nb);
    chk("inflight_len", nb, DC + 1);
    chk("inflight_LO", LO, 32'd14);
    chk("inflight_HI", HI, 32'd2);

    simple_op(4'd1, 32'h8000_0000, 32'h8000_0000, nb);
    chk("mult_min_HI", HI, 32'h4000_0000);
    chk("mult_min_LO", LO, 32'd0);

    simple_op(4'd3, 32'd7, 32'hFFFF_FFFE, nb);
    chk("div_negb_LO", LO, 32'hFFFF_FFFD);
    chk("div_negb_HI", HI, 32'd1);

    tick; mdu_op = 4'd7; A = 32'hAAAA; flush = 1'b1;
    tick; mdu_op = 4'd8; A = 32'h55; flush = 1'b0;
    tick; mdu_op = 4'd0;
    @(negedge clk);
    chk("mthi_flush_HI", HI, 32'd1);
    chk("mtlo_LO", LO, 32'h55);

    tick; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
    tick; mdu_op = 4'd0;
    tick; tick;
    tick; reset = 1'b1;
    tick; reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);

    simple_op(4'd1, 32'd6, 32'd7, nb);
    chk("postrst_len", nb, MC + 1);
    chk("postrst_LO", LO, 32'd42);
    chk("postrst_HI", HI, 32'd0);

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
